// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter for the two result producers, driving the
// register file write port through one register stage plus a pending-write scoreboard.
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [4:0]      s0_rd,
  input  logic [XLEN-1:0] s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [4:0]      s1_rd,
  input  logic [XLEN-1:0] s1_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            reg_wen,
  output logic [5:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  // state   | meaning
  // PRI_S0  | src0 wins a tie (src1 granted most recently, or reset)
  // PRI_S1  | src1 wins a tie (src0 granted most recently)
  typedef enum logic {PRI_S0 = 1'b0, PRI_S1 = 1'b1} pri_t;

  pri_t            pri_q, pri_d;
  logic            hs0, hs1, commit;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] busy_d;

  always_comb begin
    s0_ready = s0_valid && (!s1_valid || (pri_q == PRI_S0));
    s1_ready = s1_valid && (!s0_valid || (pri_q == PRI_S1));
    hs0      = s0_valid && s0_ready;
    hs1      = s1_valid && s1_ready;
    win_rd   = hs0 ? s0_rd   : s1_rd;
    win_data = hs0 ? s0_data : s1_data;
    commit   = (hs0 || hs1) && (win_rd != 5'd0);

    pri_d = pri_q;
    if (hs0)      pri_d = PRI_S1;
    else if (hs1) pri_d = PRI_S0;
  end

  // Clear first, then set, so a new writer issued on the commit edge stays pending.
  always_comb begin
    busy_d = busy;
    if (commit)
      busy_d[win_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign hazard = ((chk_rs1 != 5'd0) && busy[chk_rs1]) ||
                  ((chk_rs2 != 5'd0) && busy[chk_rs2]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pri_q   <= PRI_S0;
      busy    <= '0;
      reg_wen <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      pri_q   <= pri_d;
      busy    <= busy_d;
      reg_wen <= commit;
      if (commit) begin
        rd_addr <= {1'b0, win_rd};
        rd_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a behavioural
// model of the grant, writeback and scoreboard rules.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_rd, s1_rd, issue_rd, chk_rs1, chk_rs2;
  logic [31:0] s0_data, s1_data, rd_data;
  logic        issue_valid, hazard, reg_wen;
  logic [31:0] busy;
  logic [5:0]  rd_addr;

  wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rstn(rstn),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .busy(busy),
    .reg_wen(reg_wen), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: last winning source (1 at reset, so src0 wins the first tie)
  int          last_win;
  logic [31:0] exp_busy;
  logic        exp_wen;
  logic [5:0]  exp_addr;
  logic [31:0] exp_data;
  logic        acc0, acc1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_win = 1;
    exp_busy = '0;
    exp_wen  = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    acc0 = 1'b0;
    acc1 = 1'b0;
  endtask

  // Entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    logic e0, e1, ehz;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    #1;
    e0  = s0_valid && (!s1_valid || last_win != 0);
    e1  = s1_valid && (!s0_valid || last_win == 0);
    ehz = (chk_rs1 != 0 && exp_busy[chk_rs1]) || (chk_rs2 != 0 && exp_busy[chk_rs2]);
    check("s0_ready", s0_ready, e0);
    check("s1_ready", s1_ready, e1);
    check("hazard", hazard, ehz);
    @(posedge clk);
    acc0 = e0;
    acc1 = e1;
    wrd  = 5'd0;
    wdat = 32'd0;
    if (e0) begin
      last_win = 0; wrd = s0_rd; wdat = s0_data;
    end else if (e1) begin
      last_win = 1; wrd = s1_rd; wdat = s1_data;
    end
    exp_wen = (e0 || e1) && wrd != 0;
    if (exp_wen) begin
      exp_addr = {1'b0, wrd};
      exp_data = wdat;
      exp_busy[wrd] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) exp_busy[issue_rd] = 1'b1;
    #1;
    check("reg_wen", reg_wen, exp_wen);
    check("rd_addr", rd_addr, exp_addr);
    check("rd_data", rd_data, exp_data);
    check("busy", busy, exp_busy);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_wen", reg_wen, 1'b0);
    check("rst_busy", busy, 32'd0);
    check("rst_addr", rd_addr, 6'd0);
    check("rst_data", rd_data, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s1_valid = 0; issue_valid = 0;
    s0_rd = 0; s1_rd = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    s0_data = 0; s1_data = 0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_busy", busy, 32'd0);
    check("init_wen", reg_wen, 1'b0);
    rstn = 1'b1;

    // reset while a write pulse is on the port
    s0_valid = 1; s0_rd = 5'd3; s0_data = 32'hA5A5_0003;
    issue_valid = 1; issue_rd = 5'd12;
    cycle();
    check("pre_rst_wen", reg_wen, 1'b1);
    do_reset();
    idle_inputs();

    // single source
    s0_valid = 1; s0_rd = 5'd5; s0_data = 32'hDEAD_BEEF;
    cycle();
    check("single_wen", reg_wen, 1'b1);
    check("single_addr", rd_addr, 6'd5);
    check("single_data", rd_data, 32'hDEAD_BEEF);
    s0_valid = 0;
    cycle();
    check("single_wen_drop", reg_wen, 1'b0);

    // x0 discard from src1
    s1_valid = 1; s1_rd = 5'd0; s1_data = 32'h1234;
    cycle();
    check("x0_wen", reg_wen, 1'b0);
    s1_valid = 0;

    // contention: expect s0, s1, s0, s1
    s0_valid = 1; s0_rd = 5'd10; s0_data = 32'h100;
    s1_valid = 1; s1_rd = 5'd20; s1_data = 32'h200;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] want;
      want = (i % 2 == 0) ? {1'b0, s0_rd} : {1'b0, s1_rd};
      cycle();
      check("cont_wen", reg_wen, 1'b1);
      check("cont_order", rd_addr, want);
      if (acc0) begin s0_rd = s0_rd + 5'd1; s0_data = s0_data + 32'd1; end
      if (acc1) begin s1_rd = s1_rd + 5'd1; s1_data = s1_data + 32'd1; end
    end
    s0_valid = 0; s1_valid = 0;

    // scoreboard set, hazard, clear
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    issue_valid = 0; chk_rs1 = 5'd7;
    #1 check("sb_hazard", hazard, 1'b1);
    s0_valid = 1; s0_rd = 5'd7; s0_data = 32'h7777;
    cycle();
    check("sb_clear", busy[7], 1'b0);
    check("sb_hazard_clr", hazard, 1'b0);
    s0_valid = 0; chk_rs1 = 0;

    // simultaneous set and clear of r9
    issue_valid = 1; issue_rd = 5'd9;
    s1_valid = 1; s1_rd = 5'd9; s1_data = 32'h9999;
    cycle();
    check("sim_busy9", busy[9], 1'b1);
    check("sim_wen", reg_wen, 1'b1);
    check("sim_addr", rd_addr, 6'd9);
    idle_inputs();
    cycle();

    // randomized traffic; producers hold their item until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!(s0_valid && !acc0)) begin
        s0_valid = ($urandom_range(0, 3) != 0);
        s0_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        s0_data  = $urandom;
      end
      if (!(s1_valid && !acc1)) begin
        s1_valid = ($urandom_range(0, 3) != 0);
        s1_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        s1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom);
      chk_rs1     = 5'($urandom);
      chk_rs2     = 5'($urandom);
      if (n == 1500) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side companion to the 32x32 register file.
- Accepts writeback results from two producers: src0 = ALU, src1 = load/store unit. Each producer uses a valid/ready handshake.
- Arbitrates the producers round-robin and drives the register file's single write port through a registered stage.
- Keeps a pending-write scoreboard so the decode stage can detect read-after-write hazards on rs1/rs2.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers; must be 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset; clears all state immediately.
- s0_valid  input  1  ALU result valid.
- s0_ready  output  1  ALU result accepted this cycle.
- s0_rd  input  5  ALU destination register.
- s0_data  input  XLEN  ALU result.
- s1_valid  input  1  LSU result valid.
- s1_ready  output  1  LSU result accepted this cycle.
- s1_rd  input  5  LSU destination register.
- s1_data  input  XLEN  LSU result.
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  5  destination of the issued instruction.
- chk_rs1  input  5  decode source 1 to check.
- chk_rs2  input  5  decode source 2 to check.
- hazard  output  1  combinational; high when busy[chk_rs1] or busy[chk_rs2] is set.
- busy  output  NREG  pending-write bitmap.
- reg_wen  output  1  register file write enable.
- rd_addr  output  6  register file write address; bit 5 is always 0.
- rd_data  output  XLEN  register file write data.

Behaviour:
- Reset (rstn low, asynchronous): outputs and state take these values regardless of clk.
  - reg_wen=0, rd_addr=0, rd_data=0, busy=0.
  - Round-robin pointer set so src0 has priority.
  - s0_ready and s1_ready follow the combinational grant rule but cannot complete a handshake while rstn is low.
- Grant rule (combinational; the register file never back-pressures, so the arbiter accepts one result every cycle):
  - Only one source valid: that source gets ready=1.
  - Both valid: the source not granted most recently gets ready=1, the other gets 0.
  - Neither valid: both ready=0.
- Handshake completes when valid && ready are both high at a rising edge.
- A producer holds valid, rd and data stable until its handshake completes. The arbiter does not check this.
- Priority pointer updates only on a completed handshake, to point away from the winner.
- Output stage latency is 1 cycle. On the edge after a handshake with rd != 0:
  - reg_wen=1, rd_addr={1'b0,rd}, rd_data=data.
  - reg_wen is a single-cycle pulse unless another handshake completes on the next edge.
- No handshake in a cycle: the next cycle has reg_wen=0. rd_addr and rd_data hold their last values.
- Handshake with rd == 0: the result is accepted and discarded. reg_wen stays 0 and busy is unchanged.
- Scoreboard set: at the edge, issue_valid && issue_rd != 0 sets busy[issue_rd].
- Scoreboard clear: at the edge, a completed handshake with rd != 0 clears busy[rd].
- Set and clear of the same register at the same edge: set wins, because the newer writer is pending. Sets and clears of different registers apply together.
- busy[0] is always 0.
- Clearing a register whose busy bit is not set is legal and has no effect.
- Multiple outstanding writers to one register are not counted; the first commit clears the bit. Decode must not issue a second writer to a busy register; hazard supports this.
- hazard is purely combinational from busy, chk_rs1 and chk_rs2. chk_rsX == 0 never raises hazard.
- Reset mid-operation: any pending result is lost. reg_wen drops immediately and busy clears.

Test Plan:
- Reset: assert rstn=0 with reg_wen pulsing. Required: reg_wen=0, busy=0 and rd_addr=0 without waiting for a clk edge.
- Single source: s0 writes rd=5, data=0xDEADBEEF. Required: s0_ready=1 that cycle; the next cycle reg_wen=1, rd_addr=5, rd_data=0xDEADBEEF; the cycle after, reg_wen=0.
- Contention: s0 and s1 both valid for 4 cycles with distinct rd. Required: grants go s0, s1, s0, s1; four consecutive reg_wen pulses in the same order.
- x0 discard: s1 writes rd=0, data=0x1234. Required: s1_ready=1, reg_wen stays 0, busy unchanged.
- Scoreboard: issue rd=7, then chk_rs1=7. Required: hazard=1. Then s0 commits rd=7. Required: busy[7]=0 on that edge and hazard=0 after it.
- Simultaneous set/clear: at one edge, issue rd=9 while s1 commits rd=9. Required: busy[9]=1 afterwards and reg_wen=1 with rd_addr=9 in the next cycle.
